// File: rtl/conv_pkg.sv
// Shared helpers for the convolution datapath: tree sizing and tap-index mapping
// used by the MAC pipeline and the window generator.
package conv_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int tree_stages(input int taps);
    return clog2(taps);
  endfunction

  // Operand count entering adder-tree level 'level' (ceil(taps / 2^level)).
  function automatic int tree_width(input int taps, input int level);
    int w;
    w = taps;
    for (int i = 0; i < level; i++) w = (w + 1) / 2;
    return w;
  endfunction

  // Window tap paired with filter tap i; flip gives the 180-degree rotated kernel.
  function automatic int tap_src(input int i, input int taps, input logic flip);
    return flip ? (taps - 1 - i) : i;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered binary adder tree with valid/last/relu/bias sideband; one level per cycle.
// Assumes N >= 4 (K >= 2), so there are at least two levels.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int N         = 9,
  parameter int ACC_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   in_relu,
  input  logic [ACC_WIDTH-1:0]   in_bias,
  input  logic [N*ACC_WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   out_relu,
  output logic [ACC_WIDTH-1:0]   out_bias,
  output logic [ACC_WIDTH-1:0]   out_sum
);

  localparam int TREE = tree_stages(N);

  logic [TREE-1:0]      vld;
  logic [TREE-1:0]      lst;
  logic [TREE-1:0]      relu_q;
  logic [ACC_WIDTH-1:0] bias_q [TREE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
    end else if (clear) begin
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      vld <= {vld[TREE-2:0], in_valid};
      lst <= {lst[TREE-2:0], in_last};
    end
  end

  // NOTE: pure data registers carry no reset; the valid bits alone decide whether they matter.
  always_ff @(posedge clk) begin
    if (en) begin
      relu_q    <= {relu_q[TREE-2:0], in_relu};
      bias_q[0] <= in_bias;
      for (int i = 1; i < TREE; i++) bias_q[i] <= bias_q[i-1];
    end
  end

  for (genvar l = 0; l < TREE; l++) begin : g_lvl
    localparam int IN_CNT  = tree_width(N, l);
    localparam int OUT_CNT = tree_width(N, l + 1);

    // Padded to an even count; the zero partner lets an odd spare operand pass through unchanged.
    logic [ACC_WIDTH-1:0] src [2*OUT_CNT];
    logic [ACC_WIDTH-1:0] sum [OUT_CNT];

    if (l == 0) begin : g_in
      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      always_comb begin
        src = '{default: '0};
        for (int j = 0; j < IN_CNT; j++) src[j] = in_data[j*ACC_WIDTH +: ACC_WIDTH];
      end
    end else begin : g_prev
      always_comb begin
        src = '{default: '0};
        for (int j = 0; j < IN_CNT; j++) src[j] = g_lvl[l-1].sum[j];
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        for (int j = 0; j < OUT_CNT; j++) sum[j] <= src[2*j] + src[2*j+1];
      end
    end
  end

  assign out_valid = vld[TREE-1];
  assign out_last  = lst[TREE-1];
  assign out_relu  = relu_q[TREE-1];
  assign out_bias  = bias_q[TREE-1];
  assign out_sum   = g_lvl[TREE-1].sum[0];

endmodule

// File: rtl/conv_mac_pipe.sv
// KxK convolution MAC: product stage, registered adder tree, channel accumulator with
// bias and optional ReLU, ready/valid backpressure and synchronous flush.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter bit SIGNED      = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush_i,
  input  logic                                      win_valid_i,
  output logic                                      win_ready_o,
  input  logic                                      win_last_i,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data_i,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] filt_data_i,
  input  logic                                      flip_i,
  input  logic                                      relu_en_i,
  input  logic [ACC_WIDTH-1:0]                      bias_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [ACC_WIDTH-1:0]                      out_data_o
);

  localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW = 2 * DATA_WIDTH;

  logic stall;
  logic accept;

  assign stall       = out_valid_o & ~out_ready_i;
  assign win_ready_o = ~stall & ~flush_i;
  assign accept      = win_valid_i & win_ready_o;

  logic [N*ACC_WIDTH-1:0]   prod;
  logic [DATA_WIDTH-1:0]    w_tap;
  logic [DATA_WIDTH-1:0]    f_tap;
  logic signed [PW-1:0]     p_signed;
  logic [PW-1:0]            p_unsigned;

  always_comb begin
    prod       = '0;
    w_tap      = '0;
    f_tap      = '0;
    p_signed   = '0;
    p_unsigned = '0;
    for (int i = 0; i < N; i++) begin
      w_tap = win_data_i[tap_src(i, N, flip_i)*DATA_WIDTH +: DATA_WIDTH];
      f_tap = filt_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      if (SIGNED) begin
        p_signed = PW'($signed(w_tap)) * PW'($signed(f_tap));
        prod[i*ACC_WIDTH +: ACC_WIDTH] = {{(ACC_WIDTH-PW){p_signed[PW-1]}}, p_signed};
      end else begin
        p_unsigned = PW'(w_tap) * PW'(f_tap);
        prod[i*ACC_WIDTH +: ACC_WIDTH] = {{(ACC_WIDTH-PW){1'b0}}, p_unsigned};
      end
    end
  end

  logic                   s0_valid;
  logic                   s0_last;
  logic                   s0_relu;
  logic [ACC_WIDTH-1:0]   s0_bias;
  logic [N*ACC_WIDTH-1:0] s0_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
    end else if (flush_i) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
    end else if (!stall) begin
      s0_valid <= accept;
      s0_last  <= accept & win_last_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && accept) begin
      s0_prod <= prod;
      s0_bias <= bias_i;
      s0_relu <= relu_en_i;
    end
  end

  logic                 t_valid;
  logic                 t_last;
  logic                 t_relu;
  logic [ACC_WIDTH-1:0] t_bias;
  logic [ACC_WIDTH-1:0] t_sum;

  conv_adder_tree #(
    .N         (N),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (~stall),
    .clear     (flush_i),
    .in_valid  (s0_valid),
    .in_last   (s0_last),
    .in_relu   (s0_relu),
    .in_bias   (s0_bias),
    .in_data   (s0_prod),
    .out_valid (t_valid),
    .out_last  (t_last),
    .out_relu  (t_relu),
    .out_bias  (t_bias),
    .out_sum   (t_sum)
  );

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] result;

  assign result = acc + t_sum + t_bias;

  // When not stalled the current result is either absent or being taken, so valid can drop
  // unconditionally and be re-raised by a new last beat in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (flush_i) begin
      acc         <= '0;
      out_valid_o <= 1'b0;
    end else if (!stall) begin
      out_valid_o <= 1'b0;
      if (t_valid) begin
        if (t_last) begin
          acc         <= '0;
          out_valid_o <= 1'b1;
          out_data_o  <= (SIGNED && t_relu && result[ACC_WIDTH-1]) ? '0 : result;
        end else begin
          acc <= acc + t_sum;
        end
      end
    end
  end

endmodule
